fft_reorder_ctrl: RTL and testbench
===================================

# fft_reorder_ctrl

Ping-pong controller that sequences two 8-entry bit-reversal reorder register banks (reg_sort instances) at the output of the 64-point FFT radix stage. It accepts a valid/ready sample stream, writes each 8-sample group into the free bank at natural-order addresses, and drains the filled bank in bit-reversed order through a valid/ready output port. While one bank drains, the other fills, so sustained throughput is one sample per cycle. The bit-reversal itself is done inside the bank; this block owns only the sequencing, bank selection, flow control and frame bookkeeping.

## Interface

Parameters:
- ADDR_W, 3, bank address width. Only 3 is supported; it must match the bank depth of 8.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  an input sample is present.
- in_sop  in  1  start of group. Qualified by in_valid.
- in_ready  out  1  the controller accepts a sample this cycle.
- w_en0 / w_en1  out  1 each  write enable to bank 0 / bank 1.
- w_addr  out  ADDR_W  write address shared by both banks. It equals wr_cnt.
- r_en0 / r_en1  out  1 each  read enable to bank 0 / bank 1.
- r_addr  out  ADDR_W  read address shared by both banks. It equals rd_cnt.
- out_sel  out  1  output mux select. It equals rb and selects the bank driving the output data.
- out_valid  out  1  the selected bank holds a readable sample.
- out_ready  in  1  the downstream stage accepts the sample.
- out_last  out  1  out_valid is high and rd_cnt is 7.
- frame_err  out  1  one-cycle registered pulse flagging a misaligned in_sop.
- frames_out  out  CNT_W  count of fully drained groups. Wraps modulo 2^CNT_W.

## Operation

State:
- wb: write-bank pointer.
- rb: read-bank pointer.
- full[1:0]: per-bank full flags.
- wr_cnt, rd_cnt: 3-bit address counters.
- frame_err register and frames_out register.

Combinational outputs:
- in_ready = !full[wb].
- out_valid = full[rb].
- w_enN = in_valid & in_ready & (wb==N).
- r_enN = out_valid & (rb==N).
- r_en is asserted whenever out_valid is high, independent of out_ready, because bank reads are combinational.

Write handshake (in_valid & in_ready):
- Normally: wr_cnt increments.
- At wr_cnt==7: wr_cnt wraps to 0, full[wb] is set, and wb toggles.

Read handshake (out_valid & out_ready):
- Normally: rd_cnt increments.
- At rd_cnt==7: rd_cnt wraps to 0, full[rb] clears, rb toggles, and frames_out increments.

Misaligned start of group:
- Condition: in_sop is set on a write handshake while wr_cnt!=0.
- The current partial group is abandoned. The sample is written at address 0 of the same bank (w_addr is forced to 0 that cycle) and wr_cnt becomes 1.
- frame_err pulses high on the next cycle.
- in_sop with wr_cnt==0 is normal. A group that begins without in_sop is accepted without any check.

Simultaneous events:
- A write completion and a read completion in the same cycle both take effect: one full bit sets and the other clears.
- wb==rb occurs only when that bank is empty (read idle) or full (write stalled). The controller never writes a full bank and never reads a bank that is not full.
- A misaligned in_sop never affects a bank that is already full.

Reset (rst_n low at a clock edge), including mid-operation:
- Clears wb, rb, full, wr_cnt, rd_cnt, frame_err and frames_out.
- After reset: in_ready=1, out_valid=0, out_last=0, all enables 0 unless in_valid is high.
- Any in-flight group is discarded. Bank contents are not cleared by this block.

## Timing

- Write latency: the 8th accepted sample of a group causes out_valid to rise in the next cycle.
- Read latency: zero. Data is valid in the same cycle as out_valid.
- Throughput: with in_valid and out_ready held high, the stream is gap-free at 1 sample/cycle after the initial 8-cycle fill.
- Input stall: in_ready drops only when both banks are full, i.e. 16 samples are held and out_ready is low.
- frame_err is high for exactly one cycle, the cycle after the offending handshake.
- frames_out updates on the edge that completes the drain.

## Test plan

- Reset, then feed 8 samples (values 0..7) with out_ready=1.
  - Required: w_addr steps 0..7 on bank 0, and out_valid rises in the next cycle.
  - Required: r_addr steps 0..7 on bank 0, out_sel=0, out_last is high on the 8th read, and frames_out=1.
- Continuous stream of 64 samples with out_ready=1.
  - Required: no in_ready deassertion, banks alternate every 8 samples, frames_out=8, and output is gap-free from cycle 9 to cycle 72.
- out_ready=0 while 20 samples are offered.
  - Required: in_ready drops after 16 accepted samples, and full=2'b11.
  - Then raise out_ready: in_ready returns the cycle after the 8th read.
- in_sop asserted at wr_cnt==5.
  - Required: w_addr=0 that cycle, wr_cnt=1 afterwards, frame_err is high for one cycle, and the group completes after 7 further samples.
- Both banks hold data, then rst_n is pulsed low for one edge.
  - Required: out_valid=0, in_ready=1, frames_out=0, and the next group lands in bank 0 at address 0.
- Write completion of bank 1 coincides with read completion of bank 0.
  - Required: full goes from 2'b01 to 2'b10 in one edge, rb=1 and wb=0.

Source files
------------

// File: rtl/fft_reorder_ctrl_if.sv
// ----------------------------------------------------------------------------
// fft_reorder_ctrl_if
//
// Bundles the sample-stream handshakes and the bank control lines of the
// ping-pong reorder controller.
//
//   in_valid / in_sop / in_ready   : upstream sample stream (valid/ready)
//   w_en0 / w_en1 / w_addr         : write port of bank 0 / bank 1
//   r_en0 / r_en1 / r_addr         : read port of bank 0 / bank 1
//   out_sel                        : output mux select (bank being drained)
//   out_valid / out_ready/out_last : downstream sample stream (valid/ready)
//   frame_err                      : one-cycle pulse, misaligned in_sop
//   frames_out                     : count of fully drained groups
//
// Modports:
//   slave  : the controller itself
//   master : the environment (upstream source, downstream sink, banks)
// ----------------------------------------------------------------------------
interface fft_reorder_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_sop;
    logic              in_ready;
    logic              w_en0;
    logic              w_en1;
    logic [ADDR_W-1:0] w_addr;
    logic              r_en0;
    logic              r_en1;
    logic [ADDR_W-1:0] r_addr;
    logic              out_sel;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              frame_err;
    logic [CNT_W-1:0]  frames_out;

    modport slave (
        input  in_valid,
        input  in_sop,
        input  out_ready,
        output in_ready,
        output w_en0,
        output w_en1,
        output w_addr,
        output r_en0,
        output r_en1,
        output r_addr,
        output out_sel,
        output out_valid,
        output out_last,
        output frame_err,
        output frames_out
    );

    modport master (
        output in_valid,
        output in_sop,
        output out_ready,
        input  in_ready,
        input  w_en0,
        input  w_en1,
        input  w_addr,
        input  r_en0,
        input  r_en1,
        input  r_addr,
        input  out_sel,
        input  out_valid,
        input  out_last,
        input  frame_err,
        input  frames_out
    );
endinterface

// File: rtl/fft_reorder_ctrl.sv
// ----------------------------------------------------------------------------
// fft_reorder_ctrl
//
// Ping-pong sequencer for two 8-entry bit-reversal reorder banks at the
// output of the 64-point FFT radix stage. Incoming samples are written in
// natural order into the bank currently being filled; a filled bank is
// drained with natural read addresses (the bank applies the bit reversal
// internally). One bank fills while the other drains, sustaining one sample
// per cycle.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : fft_reorder_ctrl_if.slave, stream handshakes and bank controls
//
// Parameters:
//   ADDR_W : bank address width, only 3 (8-entry banks) is meaningful
//   CNT_W  : width of the drained-group counter (wraps)
// ----------------------------------------------------------------------------
module fft_reorder_ctrl #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_reorder_ctrl_if.slave    bus
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Bank pointers, occupancy and counters
    logic              wb_q,        wb_d;
    logic              rb_q,        rb_d;
    logic [1:0]        full_q,      full_d;
    logic [ADDR_W-1:0] wr_cnt_q,    wr_cnt_d;
    logic [ADDR_W-1:0] rd_cnt_q,    rd_cnt_d;
    logic              frame_err_q, frame_err_d;
    logic [CNT_W-1:0]  frames_q,    frames_d;

    // Handshake qualifiers
    logic in_ready_s;
    logic out_valid_s;
    logic wr_hs_s;
    logic rd_hs_s;
    logic misalign_s;
    logic wr_last_s;
    logic rd_last_s;

    // Handshake decode: a bank is writable while not full, readable once full.
    always_comb begin
        in_ready_s  = ~full_q[wb_q];
        out_valid_s = full_q[rb_q];
        wr_hs_s     = bus.in_valid & in_ready_s;
        rd_hs_s     = out_valid_s & bus.out_ready;
        // in_sop anywhere but address 0 restarts the group in the same bank
        misalign_s  = wr_hs_s & bus.in_sop & (wr_cnt_q != ADDR_ZERO);
        // A restart never completes a group, even when it lands at address 7
        wr_last_s   = wr_hs_s & ~misalign_s & (wr_cnt_q == ADDR_LAST);
        rd_last_s   = rd_hs_s & (rd_cnt_q == ADDR_LAST);
    end

    // Write-side next state: address counter and fill-bank pointer.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wb_d     = wb_q;
        if (misalign_s) begin
            // The restarting sample occupies address 0, so continue from 1
            wr_cnt_d = ADDR_ONE;
        end else if (wr_last_s) begin
            wr_cnt_d = ADDR_ZERO;
            wb_d     = ~wb_q;
        end else if (wr_hs_s) begin
            wr_cnt_d = wr_cnt_q + ADDR_ONE;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
    end

    // Read-side next state: address counter, drain-bank pointer, group count.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        rb_d     = rb_q;
        frames_d = frames_q;
        if (rd_last_s) begin
            rd_cnt_d = ADDR_ZERO;
            rb_d     = ~rb_q;
            frames_d = frames_q + CNT_ONE;
        end else if (rd_hs_s) begin
            rd_cnt_d = rd_cnt_q + ADDR_ONE;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
    end

    // Occupancy next state. A fill and a drain completing together touch
    // different banks (the fill bank is empty, the drain bank is full), so
    // both updates apply independently.
    always_comb begin
        full_d = full_q;
        if (wr_last_s) begin
            full_d[wb_q] = 1'b1;
        end else begin
            full_d[wb_q] = full_q[wb_q];
        end
        if (rd_last_s) begin
            full_d[rb_q] = 1'b0;
        end else begin
            full_d[rb_q] = full_d[rb_q];
        end
    end

    // Misalignment flag is reported one cycle after the offending handshake.
    always_comb begin
        frame_err_d = misalign_s;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            full_q      <= 2'b00;
            wr_cnt_q    <= ADDR_ZERO;
            rd_cnt_q    <= ADDR_ZERO;
            frame_err_q <= 1'b0;
            frames_q    <= CNT_ZERO;
        end else begin
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            full_q      <= full_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            frame_err_q <= frame_err_d;
            frames_q    <= frames_d;
        end
    end

    // Bank controls are combinational so a write or a read takes effect in
    // the same cycle as its handshake; read enables follow out_valid alone
    // because bank reads are combinational.
    assign bus.in_ready   = in_ready_s;
    assign bus.w_en0      = wr_hs_s & ~wb_q;
    assign bus.w_en1      = wr_hs_s & wb_q;
    assign bus.w_addr     = misalign_s ? ADDR_ZERO : wr_cnt_q;
    assign bus.r_en0      = out_valid_s & ~rb_q;
    assign bus.r_en1      = out_valid_s & rb_q;
    assign bus.r_addr     = rd_cnt_q;
    assign bus.out_sel    = rb_q;
    assign bus.out_valid  = out_valid_s;
    assign bus.out_last   = out_valid_s & (rd_cnt_q == ADDR_LAST);
    assign bus.frame_err  = frame_err_q;
    assign bus.frames_out = frames_q;

endmodule

// File: tb/tb_fft_reorder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft_reorder_ctrl
//
// Drives the reorder controller through directed scenarios and a randomized
// run. Two behavioural 8-entry banks (natural write, bit-reversed read) sit
// behind the controller's bank controls so the output sample order can be
// checked end to end. The reference model works at group level: a queue for
// the group being collected, a queue of expected output samples, and counts
// of groups filled and drained since reset.
// ----------------------------------------------------------------------------
module tb_fft_reorder_ctrl;

    localparam int AW = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_reorder_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) ifc ();

    fft_reorder_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // 3-bit bit reversal by arithmetic
    function automatic int rev3(input int k);
        int r;
        r = 0;
        for (int b = 0; b < 3; b++) r = r * 2 + ((k >> b) % 2);
        return r;
    endfunction

    // Behavioural banks: natural-order write, bit-reversed read
    logic [15:0] din;
    logic [15:0] dout;
    logic [15:0] tb_bank [0:1][0:7];

    always @(posedge clk) begin
        if (ifc.w_en0) tb_bank[0][ifc.w_addr] <= din;
        if (ifc.w_en1) tb_bank[1][ifc.w_addr] <= din;
    end

    always_comb dout = tb_bank[ifc.out_sel][3'(rev3(int'(ifc.r_addr)))];

    // Reference model state
    int          m_wg, m_rg, m_rcnt, m_frames;
    logic        m_ferr;
    logic [15:0] cur[$];
    logic [15:0] exp_out[$];

    // Observed and expected per-cycle values
    logic        obs_in_ready, obs_out_valid, obs_w_en0, obs_w_en1, obs_r_en0, obs_r_en1;
    logic        obs_out_sel, obs_out_last, obs_frame_err;
    logic [2:0]  obs_w_addr, obs_r_addr;
    logic [15:0] obs_frames, obs_dout;
    logic        e_in_ready, e_out_valid, e_w_en0, e_w_en1, e_r_en0, e_r_en1;
    logic        e_out_sel, e_out_last, e_frame_err;
    logic [2:0]  e_w_addr, e_r_addr;
    logic [15:0] e_frames, e_dout;
    logic [14:0] obs_vec, e_vec;

    task automatic do_reset();
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_sop    = 1'b0;
        ifc.out_ready = 1'b0;
        din           = 16'd0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_wg     = 0;
        m_rg     = 0;
        m_rcnt   = 0;
        m_frames = 0;
        m_ferr   = 1'b0;
        cur.delete();
        exp_out.delete();
    endtask

    // One clock cycle: drive inputs, sample DUT and model at the falling
    // edge, then advance the model across the rising edge.
    task automatic tick(input logic v, input logic sop, input logic ord, input logic [15:0] d);
        int   nf;
        logic wr, rd, mis;
        ifc.in_valid  = v;
        ifc.in_sop    = sop;
        ifc.out_ready = ord;
        din           = d;
        @(negedge clk);
        obs_in_ready  = ifc.in_ready;
        obs_out_valid = ifc.out_valid;
        obs_w_en0     = ifc.w_en0;
        obs_w_en1     = ifc.w_en1;
        obs_w_addr    = ifc.w_addr;
        obs_r_en0     = ifc.r_en0;
        obs_r_en1     = ifc.r_en1;
        obs_r_addr    = ifc.r_addr;
        obs_out_sel   = ifc.out_sel;
        obs_out_last  = ifc.out_last;
        obs_frame_err = ifc.frame_err;
        obs_frames    = ifc.frames_out;
        obs_dout      = dout;

        nf          = m_wg - m_rg;
        e_in_ready  = (nf < 2);
        e_out_valid = (nf > 0);
        wr          = v && e_in_ready;
        rd          = e_out_valid && ord;
        mis         = wr && sop && (cur.size() != 0);
        e_w_en0     = wr && (m_wg % 2 == 0);
        e_w_en1     = wr && (m_wg % 2 == 1);
        e_w_addr    = mis ? 3'd0 : 3'(cur.size());
        e_r_en0     = e_out_valid && (m_rg % 2 == 0);
        e_r_en1     = e_out_valid && (m_rg % 2 == 1);
        e_r_addr    = 3'(m_rcnt);
        e_out_sel   = (m_rg % 2 == 1);
        e_out_last  = e_out_valid && (m_rcnt == 7);
        e_frame_err = m_ferr;
        e_frames    = 16'(m_frames);
        e_dout      = (e_out_valid && exp_out.size() > 0) ? exp_out[0] : 16'hxxxx;

        obs_vec = {obs_in_ready, obs_out_valid, obs_w_en0, obs_w_en1, obs_w_addr,
                   obs_r_en0, obs_r_en1, obs_r_addr, obs_out_sel, obs_out_last, obs_frame_err};
        e_vec   = {e_in_ready, e_out_valid, e_w_en0, e_w_en1, e_w_addr,
                   e_r_en0, e_r_en1, e_r_addr, e_out_sel, e_out_last, e_frame_err};

        @(posedge clk);
        m_ferr = mis;
        if (wr) begin
            if (mis) cur.delete();
            cur.push_back(d);
            if (cur.size() == 8) begin
                for (int k = 0; k < 8; k++) exp_out.push_back(cur[rev3(k)]);
                cur.delete();
                m_wg++;
            end
        end
        if (rd) begin
            if (exp_out.size() > 0) void'(exp_out.pop_front());
            m_rcnt++;
            if (m_rcnt == 8) begin
                m_rcnt   = 0;
                m_rg++;
                m_frames = (m_frames + 1) % 65536;
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 24 && (m_wg - m_rg) > 0; k++) tick(1'b0, 1'b0, 1'b1, 16'd0);
    endtask

    task automatic test_reset();
        do_reset();
        tick(1'b0, 1'b0, 1'b1, 16'd0);
        n_checks++;
        if ({obs_in_ready, obs_out_valid, obs_out_last, obs_w_en0, obs_w_en1, obs_r_en0, obs_r_en1} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 1000000", {obs_in_ready, obs_out_valid, obs_out_last,
                     obs_w_en0, obs_w_en1, obs_r_en0, obs_r_en1});
        end
        n_checks++;
        if (obs_frames !== 16'd0 || obs_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_counters: frames %0d ferr %b want 0 0", obs_frames, obs_frame_err);
        end
        tick(1'b1, 1'b1, 1'b0, 16'd9);
        n_checks++;
        if (obs_w_en0 !== 1'b1 || obs_w_en1 !== 1'b0 || obs_w_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_first_write: w_en0 %b w_en1 %b addr %0d want 1 0 0", obs_w_en0, obs_w_en1, obs_w_addr);
        end
    endtask

    task automatic test_single_group();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, (i == 0), 1'b1, 16'(i));
            n_checks++;
            if (obs_w_en0 !== 1'b1 || obs_w_addr !== 3'(i) || obs_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_write[%0d]: w_en0 %b addr %0d valid %b want 1 %0d 0",
                         i, obs_w_en0, obs_w_addr, obs_out_valid, i);
            end
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 1'b1, 16'd0);
            n_checks++;
            if (obs_out_valid !== 1'b1 || obs_r_addr !== 3'(k) || obs_out_sel !== 1'b0 ||
                obs_r_en0 !== 1'b1 || obs_out_last !== (k == 7) || obs_dout !== 16'(rev3(k))) begin
                n_fail++;
                $display("FAIL single_read[%0d]: valid %b addr %0d sel %b last %b data %0d want 1 %0d 0 %b %0d",
                         k, obs_out_valid, obs_r_addr, obs_out_sel, obs_out_last, obs_dout, k, (k == 7), rev3(k));
            end
        end
        tick(1'b0, 1'b0, 1'b1, 16'd0);
        n_checks++;
        if (obs_frames !== 16'd1 || obs_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_frames: frames %0d valid %b want 1 0", obs_frames, obs_out_valid);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 72; i++) begin
            tick((i < 64), (i % 8 == 0), 1'b1, 16'(i));
            if (i < 64) begin
                n_checks++;
                if (obs_in_ready !== 1'b1 || obs_w_en1 !== ((i / 8) % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL stream_in[%0d]: ready %b w_en1 %b want 1 %b", i, obs_in_ready, obs_w_en1, ((i / 8) % 2 == 1));
                end
            end
            n_checks++;
            if (obs_out_valid !== (i >= 8) || (obs_out_valid === 1'b1 && obs_dout !== e_dout)) begin
                n_fail++;
                $display("FAIL stream_out[%0d]: valid %b data %0d want %b %0d", i, obs_out_valid, obs_dout, (i >= 8), e_dout);
            end
        end
        tick(1'b0, 1'b0, 1'b1, 16'd0);
        n_checks++;
        if (obs_frames !== 16'd8) begin
            n_fail++;
            $display("FAIL stream_frames: got %0d want 8", obs_frames);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        do_reset();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, (i % 8 == 0), 1'b0, 16'(i));
            if (obs_in_ready === 1'b1) acc++;
        end
        n_checks++;
        if (acc !== 16) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d want 16", acc);
        end
        tick(1'b0, 1'b0, 1'b0, 16'd0);
        n_checks++;
        if (obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_both_full: ready %b valid %b want 0 1", obs_in_ready, obs_out_valid);
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 1'b1, 16'd0);
            n_checks++;
            if (obs_in_ready !== 1'b0 || obs_dout !== 16'(rev3(k))) begin
                n_fail++;
                $display("FAIL bp_drain[%0d]: ready %b data %0d want 0 %0d", k, obs_in_ready, obs_dout, rev3(k));
            end
        end
        tick(1'b0, 1'b0, 1'b0, 16'd0);
        n_checks++;
        if (obs_in_ready !== 1'b1 || obs_out_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_return: ready %b sel %b want 1 1", obs_in_ready, obs_out_sel);
        end
        drain();
    endtask

    task automatic test_misaligned_sop();
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, (i == 0), 1'b0, 16'(100 + i));
        tick(1'b1, 1'b1, 1'b0, 16'd200);
        n_checks++;
        if (obs_w_addr !== 3'd0 || obs_w_en0 !== 1'b1 || obs_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sop_restart: addr %0d w_en0 %b ferr %b want 0 1 0", obs_w_addr, obs_w_en0, obs_frame_err);
        end
        for (int j = 0; j < 7; j++) begin
            tick(1'b1, 1'b0, 1'b0, 16'(201 + j));
            n_checks++;
            if (obs_frame_err !== (j == 0) || obs_w_addr !== 3'(j + 1) || obs_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sop_follow[%0d]: ferr %b addr %0d valid %b want %b %0d 0",
                         j, obs_frame_err, obs_w_addr, obs_out_valid, (j == 0), j + 1);
            end
        end
        tick(1'b0, 1'b0, 1'b1, 16'd0);
        n_checks++;
        if (obs_out_valid !== 1'b1 || obs_dout !== 16'd200) begin
            n_fail++;
            $display("FAIL sop_complete: valid %b data %0d want 1 200", obs_out_valid, obs_dout);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, (i == 0), 1'b0, 16'(i));
        drain();
        for (int i = 0; i < 16; i++) tick(1'b1, (i % 8 == 0), 1'b0, 16'(300 + i));
        tick(1'b0, 1'b0, 1'b0, 16'd0);
        n_checks++;
        if (obs_frames !== 16'd1 || obs_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_pre: frames %0d ready %b want 1 0", obs_frames, obs_in_ready);
        end
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 16'd0);
        n_checks++;
        if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1 || obs_frames !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_post: valid %b ready %b frames %0d want 0 1 0", obs_out_valid, obs_in_ready, obs_frames);
        end
        tick(1'b1, 1'b1, 1'b0, 16'd55);
        n_checks++;
        if (obs_w_en0 !== 1'b1 || obs_w_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_write: w_en0 %b addr %0d want 1 0", obs_w_en0, obs_w_addr);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, (i == 0), 1'b0, 16'(i));
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, (i == 0), 1'b1, 16'(50 + i));
            if (i == 7) begin
                n_checks++;
                if (obs_w_en1 !== 1'b1 || obs_w_addr !== 3'd7 || obs_out_last !== 1'b1 || obs_out_sel !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_coincide: w_en1 %b waddr %0d last %b sel %b want 1 7 1 0",
                             obs_w_en1, obs_w_addr, obs_out_last, obs_out_sel);
                end
            end
        end
        tick(1'b1, 1'b1, 1'b0, 16'd77);
        n_checks++;
        if (obs_out_sel !== 1'b1 || obs_out_valid !== 1'b1 || obs_in_ready !== 1'b1 ||
            obs_w_en0 !== 1'b1 || obs_dout !== 16'd50) begin
            n_fail++;
            $display("FAIL b2b_after: sel %b valid %b ready %b w_en0 %b data %0d want 1 1 1 1 50",
                     obs_out_sel, obs_out_valid, obs_in_ready, obs_w_en0, obs_dout);
        end
        drain();
    endtask

    task automatic test_random();
        logic v, sop, ord;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                v   = ($urandom_range(0, 3) != 0);
                sop = (cur.size() == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0);
                ord = (c < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                tick(v, sop, ord, 16'($urandom));
                n_checks++;
                if (obs_vec !== e_vec) begin
                    n_fail++;
                    $display("FAIL rand_ctrl[%0d]: got %b want %b", c, obs_vec, e_vec);
                end
                n_checks++;
                if (obs_frames !== e_frames) begin
                    n_fail++;
                    $display("FAIL rand_frames[%0d]: got %0d want %0d", c, obs_frames, e_frames);
                end
                if (e_out_valid) begin
                    n_checks++;
                    if (obs_dout !== e_dout) begin
                        n_fail++;
                        $display("FAIL rand_data[%0d]: got %h want %h", c, obs_dout, e_dout);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_sop    = 1'b0;
        ifc.out_ready = 1'b0;
        din           = 16'd0;
        test_reset();
        test_single_group();
        test_stream();
        test_backpressure();
        test_misaligned_sop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
